// File: rtl/rcla_accumulator_8_12.sv
// Framed sample accumulator: sums NSAMP unsigned 8-bit samples into a 12-bit total,
// presents the result with a valid/ready handshake, and records any carry-out.

module UBRCL_7_0_11_0 (
   input  logic [7:0]  a_i,
   input  logic [11:0] b_i,
   output logic [12:0] sum_o
);

   // 4-bit carry-lookahead block returning {carry_out, sum[3:0]}
   function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic ci);
      logic [3:0] g;
      logic [3:0] p;
      logic [4:0] c;
      g    = a & b;
      p    = a ^ b;
      c[0] = ci;
      c[1] = g[0] | (p[0] & ci);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | ((&p) & ci);
      return {c[4], p ^ c[3:0]};
   endfunction

   logic [11:0] a_ext_s;
   logic [4:0]  blk0_s;
   logic [4:0]  blk1_s;
   logic [4:0]  blk2_s;

   // Lookahead inside each nibble, carries ripple between nibbles
   assign a_ext_s = {4'b0000, a_i};
   assign blk0_s  = cla4(a_ext_s[3:0],  b_i[3:0],  1'b0);
   assign blk1_s  = cla4(a_ext_s[7:4],  b_i[7:4],  blk0_s[4]);
   assign blk2_s  = cla4(a_ext_s[11:8], b_i[11:8], blk1_s[4]);
   assign sum_o   = {blk2_s[4], blk2_s[3:0], blk1_s[3:0], blk0_s[3:0]};

endmodule

module rcla_accumulator_8_12 #(
   parameter int NSAMP = 16,
   parameter bit SAT   = 1'b0
) (
   input  logic        CLK,
   input  logic        RSTN,
   input  logic        CLR,
   input  logic        IV,
   output logic        IR,
   input  logic [7:0]  X,
   output logic        OV,
   input  logic        ORDY,
   output logic [11:0] S,
   output logic        OVF
);

   typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

   localparam logic [11:0] LAST_CNT = 12'(NSAMP - 1);

   state_t      state_q, state_d;
   logic [11:0] acc_q,   acc_d;
   logic [11:0] cnt_q,   cnt_d;
   logic        ovf_q,   ovf_d;
   logic [11:0] s_q,     s_d;
   logic        sovf_q,  sovf_d;
   logic [12:0] sum_s;
   logic [11:0] acc_new_s;
   logic        ovf_new_s;

   UBRCL_7_0_11_0 u_add (
      .a_i   (X),
      .b_i   (acc_q),
      .sum_o (sum_s)
   );

   assign acc_new_s = (SAT && sum_s[12]) ? 12'hFFF : sum_s[11:0];
   assign ovf_new_s = ovf_q | sum_s[12];

   // Next-state: CLR beats every handshake; published result only moves on the last accept
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      s_d     = s_q;
      sovf_d  = sovf_q;
      if (CLR) begin
         state_d = ACC;
         acc_d   = 12'd0;
         cnt_d   = 12'd0;
         ovf_d   = 1'b0;
      end else begin
         case (state_q)
            ACC: begin
               if (IV) begin
                  acc_d = acc_new_s;
                  ovf_d = ovf_new_s;
                  if (cnt_q == LAST_CNT) begin
                     cnt_d   = 12'd0;
                     s_d     = acc_new_s;
                     sovf_d  = ovf_new_s;
                     state_d = HOLD;
                  end else begin
                     cnt_d = cnt_q + 12'd1;
                  end
               end else begin
                  state_d = ACC;
               end
            end
            HOLD: begin
               if (ORDY) begin
                  state_d = ACC;
                  acc_d   = 12'd0;
                  cnt_d   = 12'd0;
                  ovf_d   = 1'b0;
               end else begin
                  state_d = HOLD;
               end
            end
            default: begin
               state_d = ACC;
               acc_d   = 12'd0;
               cnt_d   = 12'd0;
               ovf_d   = 1'b0;
            end
         endcase
      end
   end

   // State and datapath registers
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= ACC;
         acc_q   <= 12'd0;
         cnt_q   <= 12'd0;
         ovf_q   <= 1'b0;
         s_q     <= 12'd0;
         sovf_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         s_q     <= s_d;
         sovf_q  <= sovf_d;
      end
   end

   assign IR  = (state_q == ACC);
   assign OV  = (state_q == HOLD);
   assign S   = s_q;
   assign OVF = sovf_q;

endmodule

// File: doc/rcla_accumulator_8_12.md
RCLA_ACCUMULATOR_8_12 -- requirements
Module: rcla_accumulator_8_12

Interface
REQ-001 SHALL have parameter NSAMP, default 16, samples per frame, legal range 1..4095.
REQ-002 SHALL have parameter SAT, default 0: 0 = accumulator wraps modulo 4096; 1 = accumulator clamps at 4095.
REQ-003 SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RSTN, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port CLR, input, 1, synchronous frame abort/clear.
REQ-006 SHALL have port IV, input, 1, input sample valid.
REQ-007 SHALL have port IR, output, 1, ready to accept a sample.
REQ-008 SHALL have port X, input, 8, unsigned sample.
REQ-009 SHALL have port OV, output, 1, frame result valid.
REQ-010 SHALL have port ORDY, input, 1, downstream ready for the result.
REQ-011 SHALL have port S, output, 12, registered unsigned frame sum.
REQ-012 SHALL have port OVF, output, 1, frame carry-out seen (sticky within frame).

Function
REQ-013 SHALL form each new sum by instantiating UBRCL_7_0_11_0 with X as the 8-bit operand and the 12-bit accumulator as the 12-bit operand; its 13-bit result SHALL be the only adder in the datapath.
REQ-014 SHALL implement two states, ACC and HOLD; IR = 1 exactly in ACC; OV = 1 exactly in HOLD.
REQ-015 SHALL accept a sample when IV & IR; in that cycle: acc <= sum[11:0] (SAT=0) or, if sum[12]=1, 4095 (SAT=1); ovf <= ovf | sum[12]; cnt <= cnt + 1.
REQ-016 SHALL hold acc, ovf and cnt unchanged in ACC when IV = 0.
REQ-017 SHALL, on the acceptance with cnt = NSAMP-1, load S with the new acc value and OVF with the new ovf value, then enter HOLD; OV SHALL assert on the next cycle (latency 1 cycle from the last accept).
REQ-018 SHALL hold S, OVF and OV stable in HOLD while ORDY = 0.
REQ-019 SHALL, on OV & ORDY, return to ACC with acc = 0, cnt = 0, ovf = 0; IR SHALL assert the following cycle; no sample is accepted in the handshake cycle.
REQ-020 SHALL keep cnt 12 bits wide, never exceeding NSAMP-1; NSAMP = 1 SHALL enter HOLD after every accepted sample.
REQ-021 SHALL treat CLR as having priority over all handshakes: next state ACC, acc = cnt = ovf = 0, OV = 0, S and OVF unchanged; a sample presented with CLR is dropped.
REQ-022 SHALL drive S and OVF only from registers; they SHALL change only on a last-sample accept or on reset.

Reset
REQ-023 SHALL, on RSTN = 0, immediately and asynchronously force state ACC, acc = 0, cnt = 0, ovf = 0, S = 0, OVF = 0, OV = 0, IR = 1 after release.
REQ-024 SHALL, on reset asserted in any state (including mid-frame or HOLD), discard partial frame and pending result with no output handshake.
REQ-025 SHALL sample first input on the first rising CLK edge after RSTN deasserts.

Verification
REQ-026 NSAMP=4, X=1,2,3,4 back-to-back, ORDY=1 -> OV one cycle after 4th accept, S=10, OVF=0, IR high again after handshake.
REQ-027 NSAMP=17, SAT=0, X=255 x17 -> S=239, OVF=1; same with SAT=1 -> S=4095, OVF=1.
REQ-028 NSAMP=4, ORDY=0 for 5 cycles in HOLD, IV=1 throughout -> S/OV stable, IR=0, no sample consumed until handshake.
REQ-029 NSAMP=4, two samples accepted (X=7,9), then CLR with IV=1, X=50, then X=1,1,1,1 -> S=4 (not 20 or 70), OVF=0.
REQ-030 RSTN pulsed low in HOLD with S=10 -> S=0, OV=0 asynchronously; next frame X=2 x4 -> S=8.
REQ-031 NSAMP=1, X=200,100 with IV gaps -> two results S=200 then S=100, each 1 cycle after accept.
